somador_serial: RTL and testbench

//   Bit-serial N-bit adder built around the one-bit full-adder (3-input) cell.

---
 rtl/somador_serial.sv | 96 +++++++++
 tb/tb_somador_serial.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/somador_serial.sv
// Bit-serial N-bit unsigned adder: one full-adder step per clock, LSB first,
// carry kept in a flop, result and final carry published with a one-cycle pronto pulse.
module somador_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] soma,
    output logic         cout,
    output logic         ocupado,
    output logic         pronto
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {OCIOSO, SOMANDO, FIM} estado_t;

    estado_t        estado_q;
    logic [N-1:0]   a_q, b_q, sum_q, soma_q;
    logic [N-1:0]   sum_d;
    logic [CW-1:0]  cnt_q;
    logic           c_q, cout_q, ocupado_q, pronto_q;
    logic           s_bit, c_nxt;

    // The full-adder cell operating on the current LSBs and the stored carry.
    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    // New sum bit enters from the MSB side so that after N steps bit 0 lands at LSB.
    always_comb begin
        sum_d        = sum_q >> 1;
        sum_d[N-1]   = s_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            soma_q    <= '0;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            cout_q    <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    pronto_q <= 1'b0;
                    if (inicio) begin
                        a_q       <= a;
                        b_q       <= b;
                        c_q       <= 1'b0;
                        cnt_q     <= '0;
                        sum_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= SOMANDO;
                    end
                end
                SOMANDO: begin
                    sum_q <= sum_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        soma_q    <= sum_d;
                        cout_q    <= c_nxt;
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= FIM;
                    end
                end
                FIM: begin
                    pronto_q <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign soma    = soma_q;
    assign cout    = cout_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: table vectors, exhaustive and random
// operand pairs against plain a+b, plus reset, ignored-start and N=8 / N=1 sequences.
module tb_somador_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       inicio4 = 1'b0, inicio8 = 1'b0, inicio1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, soma4;
    logic [7:0] a8 = '0, b8 = '0, soma8;
    logic [0:0] a1 = '0, b1 = '0, soma1;
    logic       cout4, ocupado4, pronto4;
    logic       cout8, ocupado8, pronto8;
    logic       cout1, ocupado1, pronto1;

    somador_serial #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .inicio(inicio4), .a(a4), .b(b4),
        .soma(soma4), .cout(cout4), .ocupado(ocupado4), .pronto(pronto4));
    somador_serial #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .inicio(inicio8), .a(a8), .b(b8),
        .soma(soma8), .cout(cout8), .ocupado(ocupado8), .pronto(pronto8));
    somador_serial #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .inicio(inicio1), .a(a1), .b(b1),
        .soma(soma1), .cout(cout1), .ocupado(ocupado1), .pronto(pronto1));

    int nvec = 0;
    int nerr = 0;
    int prev_sum = 0;   // {cout,soma} last published by dut4, must stay visible while busy

    typedef struct {
        int a;
        int b;
        int soma;
        int cout;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One addition on dut4, started from OCIOSO at a negedge. Optionally pulses
    // inicio with a=1,b=1 mid-addition, which must be ignored.
    task automatic add4(input int xa, input int xb, input bit noise);
        int busy, exp;
        bit seen;
        exp = (xa + xb) & 31;
        a4 = 4'(xa); b4 = 4'(xb); inicio4 = 1'b1;
        @(posedge clk); #1;
        inicio4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        busy = 0; seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (pronto4) seen = 1;
            else begin
                if (ocupado4) busy++;
                if (t == 0) chk("old_result_held", {cout4, soma4}, prev_sum);
                if (noise && t == 1) begin inicio4 = 1'b1; a4 = 4'd1; b4 = 4'd1; end
                if (noise && t == 2) inicio4 = 1'b0;
            end
        end
        chk("pronto_seen", seen, 1);
        chk("sum", {cout4, soma4}, exp);
        chk("ocupado_cycles", busy, 4);
        chk("ocupado_low_at_pronto", ocupado4, 0);
        prev_sum = exp;
        @(negedge clk);
        chk("pronto_one_cycle", pronto4, 0);
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{a: 0,  b: 0,  soma: 0,  cout: 0};
        vt[1] = '{a: 5,  b: 3,  soma: 8,  cout: 0};
        vt[2] = '{a: 15, b: 1,  soma: 0,  cout: 1};
        vt[3] = '{a: 15, b: 15, soma: 14, cout: 1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_soma", soma4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_ocupado", ocupado4, 0);
        chk("rst_pronto", pronto4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors, expected values written out by hand
        foreach (vt[i]) begin
            add4(vt[i].a, vt[i].b, 0);
            chk("tbl_soma", soma4, vt[i].soma);
            chk("tbl_cout", cout4, vt[i].cout);
        end

        // exhaustive, back-to-back
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                add4(x, y, 0);

        // random pairs with random idle gaps
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            add4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
        end

        // start request during SOMANDO is ignored, no second pronto
        add4(6, 7, 1);
        chk("ignored_start_soma", soma4, 13);
        chk("ignored_start_cout", cout4, 0);
        begin
            int extra = 0;
            repeat (8) begin @(negedge clk); if (pronto4 || ocupado4) extra++; end
            chk("no_second_pronto", extra, 0);
        end

        // reset in the 2nd SOMANDO cycle
        begin
            int late = 0;
            a4 = 4'd9; b4 = 4'd9; inicio4 = 1'b1;
            @(posedge clk); #1 inicio4 = 1'b0;
            @(negedge clk); @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst_soma", soma4, 0);
            chk("midrst_cout", cout4, 0);
            chk("midrst_ocupado", ocupado4, 0);
            chk("midrst_pronto", pronto4, 0);
            rst_n = 1'b1;
            repeat (8) begin @(negedge clk); if (pronto4 || ocupado4) late++; end
            chk("midrst_no_pronto", late, 0);
            prev_sum = 0;
            add4(9, 9, 0);
            chk("after_rst_soma", soma4, 2);
            chk("after_rst_cout", cout4, 1);
        end

        // N=8: 200+100
        begin
            int busy = 0;
            bit seen = 0;
            a8 = 8'd200; b8 = 8'd100; inicio8 = 1'b1;
            @(posedge clk); #1 inicio8 = 1'b0; a8 = '0; b8 = '0;
            for (int t = 0; t < 30 && !seen; t++) begin
                @(negedge clk);
                if (pronto8) seen = 1; else if (ocupado8) busy++;
            end
            chk("n8_pronto_seen", seen, 1);
            chk("n8_ocupado_cycles", busy, 8);
            chk("n8_soma", soma8, 44);
            chk("n8_cout", cout8, 1);
        end

        // N=1: 1+1, pronto one edge after the busy cycle
        begin
            a1 = 1'b1; b1 = 1'b1; inicio1 = 1'b1;
            @(posedge clk); #1 inicio1 = 1'b0; a1 = '0; b1 = '0;
            @(negedge clk);
            chk("n1_ocupado", ocupado1, 1);
            chk("n1_pronto_early", pronto1, 0);
            @(negedge clk);
            chk("n1_pronto", pronto1, 1);
            chk("n1_soma", soma1, 0);
            chk("n1_cout", cout1, 1);
            @(negedge clk);
            chk("n1_pronto_one_cycle", pronto1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
